// File: rtl/bs_engine_scheduler.sv
// Dispatches parsed option packets to a bank of Black-Scholes engines and
// collects their prices through a second round-robin onto one tagged result port.
module bs_engine_scheduler #(
  parameter int NUM_ENG = 4,
  parameter int TAG_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   pkt_valid,
  input  logic [31:0]            sptprice,
  input  logic [31:0]            strike,
  input  logic [31:0]            rate,
  input  logic [31:0]            volatility,
  input  logic [31:0]            time_r,
  input  logic [31:0]            otype,
  input  logic [31:0]            timet,
  output logic                   pkt_take,
  output logic [223:0]           op_bus,
  output logic [NUM_ENG-1:0]     eng_start,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [32*NUM_ENG-1:0]  eng_result,
  output logic [NUM_ENG-1:0]     eng_ack,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic [2:0]             res_eng,
  output logic [NUM_ENG-1:0]     busy
);

  localparam int IW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic {C_IDLE, C_HOLD} cstate_t;
  cstate_t cstate_reg, cstate_next;

  logic [NUM_ENG-1:0] busy_reg, busy_next;
  logic [IW-1:0]      dp_reg, cp_reg;
  logic [TAG_W-1:0]   seq_reg;
  logic [TAG_W-1:0]   tag_reg [NUM_ENG];
  logic               pkt_take_q;
  logic [31:0]        result_arr [NUM_ENG];

  logic [NUM_ENG-1:0] free_mask, cand_mask;
  logic               disp_found, coll_found;
  logic [IW-1:0]      disp_idx, coll_idx;
  logic               dispatch, capture, slot_free;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_ENG) t = t - NUM_ENG;
    return IW'(t);
  endfunction

  for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_res
    assign result_arr[gi] = eng_result[32*gi +: 32];
  end

  // Only registered busy counts: a slot released this edge is free next cycle.
  assign free_mask = ~busy_reg;
  assign cand_mask = eng_done & busy_reg;

  always_comb begin
    logic [IW-1:0] idx;
    disp_found = 1'b0;
    disp_idx   = '0;
    coll_found = 1'b0;
    coll_idx   = '0;
    idx        = '0;
    for (int off = 0; off < NUM_ENG; off++) begin
      idx = wrap_add(dp_reg, off);
      if (!disp_found && free_mask[idx]) begin
        disp_found = 1'b1;
        disp_idx   = idx;
      end
      idx = wrap_add(cp_reg, off);
      if (!coll_found && cand_mask[idx]) begin
        coll_found = 1'b1;
        coll_idx   = idx;
      end
    end
  end

  // pkt_take_q blocks a second take of the same packet while the register refills.
  assign dispatch = reset && en && pkt_valid && disp_found && !pkt_take_q;
  assign pkt_take = dispatch;
  assign busy     = busy_reg;

  always_comb begin
    busy_next = busy_reg;
    if (dispatch) busy_next[disp_idx] = 1'b1;
    if (capture)  busy_next[coll_idx] = 1'b0;
  end

  // Collection FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) cstate_reg <= C_IDLE;
    else        cstate_reg <= cstate_next;
  end

  // Collection FSM: next state
  always_comb begin
    cstate_next = cstate_reg;
    case (cstate_reg)
      C_IDLE: if (capture) cstate_next = C_HOLD;
      C_HOLD: if (res_ready) cstate_next = capture ? C_HOLD : C_IDLE;
      default: cstate_next = C_IDLE;
    endcase
  end

  // Collection FSM: outputs; a handshake frees the slot for a same-cycle capture
  always_comb begin
    res_valid = (cstate_reg == C_HOLD);
    slot_free = (cstate_reg == C_IDLE) || res_ready;
    capture   = slot_free && coll_found;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pkt_take_q <= 1'b0;
      op_bus     <= '0;
      eng_start  <= '0;
      eng_ack    <= '0;
      busy_reg   <= '0;
      dp_reg     <= '0;
      cp_reg     <= '0;
      seq_reg    <= '0;
      res_data   <= '0;
      res_tag    <= '0;
      res_eng    <= '0;
      for (int i = 0; i < NUM_ENG; i++) tag_reg[i] <= '0;
    end else begin
      pkt_take_q <= dispatch;
      eng_start  <= '0;
      eng_ack    <= '0;
      busy_reg   <= busy_next;
      if (dispatch) begin
        op_bus              <= {timet, otype, time_r, volatility, rate, strike, sptprice};
        tag_reg[disp_idx]   <= seq_reg;
        seq_reg             <= seq_reg + 1'b1;
        dp_reg              <= wrap_add(disp_idx, 1);
        eng_start[disp_idx] <= 1'b1;
      end
      if (capture) begin
        res_data          <= result_arr[coll_idx];
        res_tag           <= tag_reg[coll_idx];
        res_eng           <= 3'(coll_idx);
        eng_ack[coll_idx] <= 1'b1;
        cp_reg            <= wrap_add(coll_idx, 1);
      end
    end
  end

endmodule

// File: doc/bs_engine_scheduler.md
Name: bs_engine_scheduler

Overview:
- Sits between the option-packet register and a bank of NUM_ENG Black-Scholes pricing engines.
- Takes each fully parsed option packet (seven 32-bit fields) and dispatches it to a free engine, using round-robin order.
- Collects finished prices through a second round-robin arbiter and presents them on a single valid/ready result port.
- Each result carries a sequence tag so downstream logic can restore packet order.

Parameters:
- NUM_ENG, 4, number of pricing engines (2..8).
- TAG_W, 8, width of the dispatch sequence tag; the tag wraps modulo 2^TAG_W.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  dispatch enable; 0 holds all new dispatches, collection continues.
- pkt_valid  in  1  packet register holds unused data (hasUnusedData).
- sptprice, strike, rate, volatility, time_r, otype, timet  in  32 each  parsed packet fields.
- pkt_take  out  1  one-cycle pulse consuming the packet (drives BS_READY).
- op_bus  out  224  registered operands {timet,otype,time_r,volatility,rate,strike,sptprice}.
- eng_start  out  NUM_ENG  one-hot start pulse.
- eng_done  in  NUM_ENG  per-engine result-held level.
- eng_result  in  32*NUM_ENG  per-engine price; engine i uses bits [32i+31:32i].
- eng_ack  out  NUM_ENG  one-hot pulse; the engine drops eng_done next cycle.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts.
- res_data  out  32  price.
- res_tag  out  TAG_W  sequence tag of the originating packet.
- res_eng  out  3  index of the engine that produced the result.
- busy  out  NUM_ENG  engine-occupied mask.

Behaviour:
- Reset (reset==0 at clock edge) clears: pkt_take, eng_start, eng_ack, res_valid, busy, op_bus, res_data, res_tag, res_eng, the seq counter, and both round-robin pointers. Reset mid-operation abandons in-flight work; engines are reset by the same signal.
- Dispatch condition, cycle N: en && pkt_valid && (~busy != 0) && !pkt_take_q.
  - pkt_take_q is the previous-cycle pkt_take. It blocks dispatching the same stale packet twice while the packet register advances.
- When the dispatch condition holds at cycle N:
  - pkt_take=1 combinationally in cycle N.
  - Engine k is selected as the first free engine at or after dispatch pointer dp, with wrap-around.
  - At edge N: op_bus latches the fields, tag_reg[k] <= seq, seq <= seq+1 (wraps), busy[k] <= 1, dp <= k+1 mod NUM_ENG.
  - eng_start[k]=1 for cycle N+1 only; op_bus is stable during N+1. Engines latch op_bus on start.
- The free mask uses registered busy only. An engine released at edge N is dispatchable from cycle N+1 onward, never in the same cycle as its release.
- Collection FSM states:
  - C_IDLE: if output slot is empty and any (eng_done & busy) bit is set, pick the first index j at or after collection pointer cp.
    - Register res_data=eng_result[j], res_tag=tag_reg[j], res_eng=j, res_valid=1.
    - Pulse eng_ack[j] for one cycle; busy[j] <= 0; cp <= j+1.
    - Go to C_HOLD.
  - C_HOLD: res_valid held with data stable until res_valid&&res_ready, then go to C_IDLE.
    - A new capture may occur in the same cycle as the handshake (C_IDLE behaviour applied that cycle), giving one result per cycle at full throughput.
- eng_done bits with busy=0 are ignored as spurious and never acked.
- Simultaneous dispatch and collection involving different engines are independent and both occur in the same cycle.
- en=0 stalls dispatch only; busy engines still drain.
- Latency: packet to eng_start is 1 cycle. eng_done to res_valid is 1 cycle when the slot is free.

Test Plan:
- Reset: hold reset=0 for 3 cycles with pkt_valid=1 -> all outputs 0, no pkt_take. Release -> first pkt_take next cycle, eng_start=4'b0001 one cycle later, op_bus equals the fields.
- Fill: pkt_valid held, no eng_done -> dispatches go to engines 0,1,2,3 with tags 0,1,2,3 on alternate cycles; busy=4'b1111; pkt_take stays 0 afterwards.
- Collect order: raise eng_done 3 and 1 together, res_ready=1 -> result from engine 1 out first (cp=0), then engine 3. eng_ack 4'b0010 then 4'b1000; tags match those dispatched.
- Backpressure: res_ready=0 for 5 cycles with eng_done=4'b0001 -> res_valid stable, only one eng_ack; other done engines wait.
- Tag wrap: dispatch 260 packets with TAG_W=8 -> tags go 255 then 0. Release then redispatch the same engine -> no start before release+1.
- en/reset mid-flight: en=0 -> no pkt_take, collection continues; reset asserted while busy=4'b0110 -> busy=0, res_valid=0 next cycle.
